// File: rtl/proximity_pkg.sv
// Shared types and defaults for the proximity measurement scheduler.
// Optional averaging filter is enabled by defining PROX_AVG_EN.
package proximity_pkg;

  localparam int DIST_W              = 22;
  localparam int PERIOD_CYCLES_DEF   = 12_500_000;
  localparam int TIMEOUT_CYCLES_DEF  = 2_500_000;
  localparam int ACK_CYCLES_DEF      = 16;
  localparam logic [DIST_W-1:0] NEAR_THRESH_DEF = 22'd58_000;
  localparam logic [DIST_W-1:0] FAR_THRESH_DEF  = 22'd87_000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ACK   = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4,
    TOUT  = 3'd5
  } prox_state_e;

  // Near/far hysteresis: inside the inclusive band the previous flag is kept.
  function automatic logic obstacle_next(input logic [DIST_W-1:0] d,
                                         input logic [DIST_W-1:0] near_th,
                                         input logic [DIST_W-1:0] far_th,
                                         input logic              cur);
    logic res;
    if (d < near_th) begin
      res = 1'b1;
    end else if (d > far_th) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/prox_avg4.sv
// Four-sample moving average of accepted distances; the first sample pre-fills
// the history so the output never averages in reset zeros (used under PROX_AVG_EN).
module prox_avg4
  import proximity_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DIST_W-1:0] i_sample,
  output logic [DIST_W-1:0] o_avg
);

  logic [DIST_W-1:0] r_buf [0:2];
  logic              r_primed;
  logic [DIST_W+1:0] w_sum;

  assign w_sum = {2'b00, i_sample} + {2'b00, r_buf[0]} + {2'b00, r_buf[1]} + {2'b00, r_buf[2]};

  always_comb begin
    o_avg = i_sample;
    if (r_primed) begin
      o_avg = w_sum[DIST_W+1:2];
    end else begin
      o_avg = i_sample;
    end
  end

  // History of the three most recent accepted samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_buf[2] <= '0;
      r_primed <= 1'b0;
    end else if (i_load) begin
      if (r_primed) begin
        r_buf[2] <= r_buf[1];
        r_buf[1] <= r_buf[0];
        r_buf[0] <= i_sample;
      end else begin
        r_buf[2] <= i_sample;
        r_buf[1] <= i_sample;
        r_buf[0] <= i_sample;
      end
      r_primed <= 1'b1;
    end
  end

endmodule

// File: rtl/proximity_scheduler.sv
// Periodic measurement sequencer for the ultrasonic sensor with echo timeout,
// overrun counting and hysteresis obstacle flag. Define PROX_AVG_EN for 4-sample averaging.
module proximity_scheduler
  import proximity_pkg::*;
#(
  parameter int                PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int                ACK_CYCLES     = ACK_CYCLES_DEF,
  parameter logic [DIST_W-1:0] NEAR_THRESH    = NEAR_THRESH_DEF,
  parameter logic [DIST_W-1:0] FAR_THRESH     = FAR_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              measure,
  input  logic              ready,
  input  logic [DIST_W-1:0] distance_raw,
  output logic [DIST_W-1:0] distance,
  output logic              distance_valid,
  output logic              obstacle,
  output logic              timeout_err,
  output logic [7:0]        overrun_cnt
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LIMIT   = TW'(ACK_CYCLES);

  prox_state_e       r_state;
  prox_state_e       w_state_nxt;
  logic [PW-1:0]     r_period_cnt;
  logic [TW-1:0]     r_tout_cnt;
  logic              w_tick;
  logic              w_accept;
  logic [DIST_W-1:0] w_dist_new;
  logic [DIST_W-1:0] r_distance;
  logic              r_measure;
  logic              r_dv;
  logic              r_obstacle;
  logic              r_terr;
  logic [7:0]        r_overrun;

  assign w_tick   = en && (r_period_cnt == PERIOD_LAST);
  assign w_accept = (r_state == BUSY) && ready;

`ifdef PROX_AVG_EN
  prox_avg4 u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_sample (distance_raw),
    .o_avg    (w_dist_new)
  );
`else
  assign w_dist_new = distance_raw;
`endif

  // Measurement period counter, parked at zero while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (!en || w_tick) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_tick && ready) w_state_nxt = START; else w_state_nxt = IDLE;
      START: w_state_nxt = ACK;
      ACK: begin
        if (!ready) begin
          w_state_nxt = BUSY;
        end else if (r_tout_cnt >= ACK_LIMIT) begin
          w_state_nxt = TOUT;
        end else begin
          w_state_nxt = ACK;
        end
      end
      BUSY: begin
        if (ready) begin
          w_state_nxt = DONE;
        end else if (r_tout_cnt >= TOUT_LAST) begin
          w_state_nxt = TOUT;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE:    w_state_nxt = IDLE;
      TOUT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and cycles-since-START counter (ACK time counts toward timeout)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tout_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == START) || (r_state == ACK) || (r_state == BUSY)) begin
        r_tout_cnt <= r_tout_cnt + TW'(1);
      end else begin
        r_tout_cnt <= '0;
      end
    end
  end

  // Outputs are loaded from the next state so they line up with START/DONE/TOUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_measure  <= 1'b0;
      r_dv       <= 1'b0;
      r_distance <= '0;
      r_obstacle <= 1'b0;
      r_terr     <= 1'b0;
      r_overrun  <= 8'd0;
    end else begin
      r_measure <= (w_state_nxt == START);
      r_dv      <= w_accept;
      if (w_accept) begin
        r_distance <= w_dist_new;
        r_obstacle <= obstacle_next(w_dist_new, NEAR_THRESH, FAR_THRESH, r_obstacle);
        r_terr     <= 1'b0;
      end else if (w_state_nxt == TOUT) begin
        r_terr <= 1'b1;
      end
      if (w_tick && ((r_state != IDLE) || !ready) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  assign measure        = r_measure;
  assign distance       = r_distance;
  assign distance_valid = r_dv;
  assign obstacle       = r_obstacle;
  assign timeout_err    = r_terr;
  assign overrun_cnt    = r_overrun;

endmodule

// File: tb/tb_proximity_scheduler.sv
// Directed bench for proximity_scheduler: two instances (200- and 2000-cycle timeouts),
// each driven by a sensor model with programmable ack/echo delay.
module tb_proximity_scheduler;

  logic        clk;
  logic        rst_a, en_a, ready_a, measure_a, dv_a, obst_a, terr_a;
  logic [21:0] raw_a, dist_a;
  logic [7:0]  ovr_a;
  logic        rst_b, en_b, ready_b, measure_b, dv_b, obst_b, terr_b;
  logic [21:0] raw_b, dist_b;
  logic [7:0]  ovr_b;

  int          ack_a, echo_a, ack_b, echo_b;
  logic        rel_a;
  logic [21:0] val_a, val_b;
  int          vec_cnt, err_cnt;
  int          dv_cnt_a, meas_cnt_b;
  logic [21:0] t6_in [4];
  logic [21:0] t6_exp [4];

  proximity_scheduler #(.PERIOD_CYCLES(1000), .TIMEOUT_CYCLES(200), .ACK_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .measure(measure_a), .ready(ready_a),
    .distance_raw(raw_a), .distance(dist_a), .distance_valid(dv_a), .obstacle(obst_a),
    .timeout_err(terr_a), .overrun_cnt(ovr_a)
  );

  proximity_scheduler #(.PERIOD_CYCLES(1000), .TIMEOUT_CYCLES(2000), .ACK_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .measure(measure_b), .ready(ready_b),
    .distance_raw(raw_b), .distance(dist_b), .distance_valid(dv_b), .obstacle(obst_b),
    .timeout_err(terr_b), .overrun_cnt(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial dv_cnt_a = 0;
  always @(posedge dv_a) dv_cnt_a <= dv_cnt_a + 1;
  initial meas_cnt_b = 0;
  always @(posedge measure_b) meas_cnt_b <= meas_cnt_b + 1;

  // Sensor model A; echo_a < 0 holds ready low until rel_a is raised
  initial begin
    ready_a = 1'b1;
    raw_a   = 22'd0;
    forever begin
      @(posedge clk); #1;
      if (measure_a === 1'b1) begin
        repeat (ack_a) @(posedge clk);
        #1 ready_a = 1'b0;
        if (echo_a < 0) begin
          while (!rel_a) begin
            @(posedge clk); #1;
          end
        end else begin
          repeat (echo_a - ack_a) @(posedge clk);
          #1;
        end
        raw_a   = val_a;
        ready_a = 1'b1;
      end
    end
  end

  // Sensor model B
  initial begin
    ready_b = 1'b1;
    raw_b   = 22'd0;
    forever begin
      @(posedge clk); #1;
      if (measure_b === 1'b1) begin
        repeat (ack_b) @(posedge clk);
        #1 ready_b = 1'b0;
        repeat (echo_b - ack_b) @(posedge clk);
        #1;
        raw_b   = val_b;
        ready_b = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until the selected output is high; -1 if the budget runs out
  task automatic wait_for(input int sel, input int budget, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && (n < budget)) begin
      @(posedge clk); #1;
      n++;
      case (sel)
        0:       hit = measure_a;
        1:       hit = dv_a;
        2:       hit = terr_a;
        3:       hit = measure_b;
        4:       hit = dv_b;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) n = -1;
  endtask

  initial begin
    int n;
    int dvb;
    vec_cnt = 0;
    err_cnt = 0;
    rst_a = 1'b0; en_a = 1'b0; ack_a = 2; echo_a = 50; val_a = 22'd30_000; rel_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; ack_b = 2; echo_b = 1500; val_b = 22'd90_000;
    t6_in[0] = 22'd40_000; t6_in[1] = 22'd40_000; t6_in[2] = 22'd40_000; t6_in[3] = 22'd80_000;
`ifdef PROX_AVG_EN
    t6_exp[0] = 22'd40_000; t6_exp[1] = 22'd40_000; t6_exp[2] = 22'd40_000; t6_exp[3] = 22'd50_000;
`else
    t6_exp[0] = 22'd40_000; t6_exp[1] = 22'd40_000; t6_exp[2] = 22'd40_000; t6_exp[3] = 22'd80_000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_measure", 32'(measure_a), 32'd0);
    check("rst_distance", 32'(dist_a), 32'd0);
    check("rst_dv", 32'(dv_a), 32'd0);
    check("rst_obstacle", 32'(obst_a), 32'd0);
    check("rst_timeout", 32'(terr_a), 32'd0);
    check("rst_overrun", 32'(ovr_a), 32'd0);

    // 1: first measurement a full period after enable
    rst_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b1;
    wait_for(0, 1100, n);
    check("t1_measure_latency", 32'(n), 32'd1000);
    wait_for(1, 100, n);
    check("t1_result_latency", 32'(n), 32'd51);
    check("t1_distance", 32'(dist_a), 32'd30_000);
    check("t1_obstacle", 32'(obst_a), 32'd1);
    check("t1_timeout", 32'(terr_a), 32'd0);

    // 2: hysteresis band holds, far clears
    val_a = 22'd70_000;
    wait_for(1, 1200, n);
    check("t2_distance_70k", 32'(dist_a), 32'd70_000);
    check("t2_obstacle_70k", 32'(obst_a), 32'd1);
    val_a = 22'd100_000;
    wait_for(1, 1200, n);
    check("t2_distance_100k", 32'(dist_a), 32'd100_000);
    check("t2_obstacle_100k", 32'(obst_a), 32'd0);

    // 3: echo never returns
    echo_a = -1;
    dvb    = dv_cnt_a;
    wait_for(0, 1200, n);
    check("t3_measure_seen", 32'(n > 0), 32'd1);
    wait_for(2, 300, n);
    check("t3_timeout_latency", 32'(n), 32'd200);
    check("t3_timeout_err", 32'(terr_a), 32'd1);
    check("t3_distance_held", 32'(dist_a), 32'd100_000);
    check("t3_no_dv", 32'(dv_cnt_a), 32'(dvb));
    val_a  = 22'd20_000;
    echo_a = 50;
    rel_a  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rel_a = 1'b0;
    wait_for(1, 1200, n);
    check("t3_recover_dv", 32'(n > 0), 32'd1);
    check("t3_timeout_cleared", 32'(terr_a), 32'd0);
    check("t3_distance_new", 32'(dist_a), 32'd20_000);
    check("t3_obstacle_new", 32'(obst_a), 32'd1);
    check("t3_overrun", 32'(ovr_a), 32'd0);

    // 5: reset while busy
    echo_a = 100;
    val_a  = 22'd60_000;
    wait_for(0, 1200, n);
    repeat (10) @(posedge clk);
    #1;
    dvb   = dv_cnt_a;
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("t5_distance", 32'(dist_a), 32'd0);
    check("t5_obstacle", 32'(obst_a), 32'd0);
    check("t5_timeout", 32'(terr_a), 32'd0);
    check("t5_measure", 32'(measure_a), 32'd0);
    check("t5_dv", 32'(dv_a), 32'd0);
    check("t5_overrun", 32'(ovr_a), 32'd0);
    en_a  = 1'b0;
    rst_a = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("t5_result_ignored_dv", 32'(dv_cnt_a), 32'(dvb));
    check("t5_result_ignored_dist", 32'(dist_a), 32'd0);

    // 6: filter sequence (raw pass-through unless PROX_AVG_EN)
    echo_a = 50;
    en_a   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      val_a = t6_in[i];
      wait_for(1, 1200, n);
      check("t6_distance", 32'(dist_a), 32'(t6_exp[i]));
    end

    // 4: tick lands while busy on the long-timeout instance
    rst_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b1;
    wait_for(3, 1100, n);
    check("t4_measure_latency", 32'(n), 32'd1000);
    wait_for(4, 2000, n);
    check("t4_result_latency", 32'(n), 32'd1501);
    check("t4_overrun", 32'(ovr_b), 32'd1);
    check("t4_single_measure", 32'(meas_cnt_b), 32'd1);
    check("t4_distance", 32'(dist_b), 32'd90_000);
    check("t4_obstacle", 32'(obst_b), 32'd0);
    check("t4_timeout", 32'(terr_b), 32'd0);
    wait_for(3, 1000, n);
    check("t4_next_measure", 32'(n), 32'd499);
    check("t4_measure_count", 32'(meas_cnt_b), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
